// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: op codes, FSM states,
// and the iteration-counter width helper.
package mcycle_pkg;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } mcycle_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    FIXUP   = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 32;

  // Counter must reach WIDTH-1; the extra bit keeps power-of-two widths safe.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mcycle_unit_if.sv
// Start/Busy/Done handshake plus operand/result bus between Execute stage and mcycle_unit.
interface mcycle_unit_if
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             Start;
  mcycle_op_e       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done, DivZero
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done, DivZero
  );
endinterface

// File: rtl/mcycle_unit.sv
// Multi-cycle MUL/DIV unit: shift-add multiply (LSB first) and restoring divide
// (MSB first) on operand magnitudes, with sign fix-up in a final cycle.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic         CLK,
  input logic         Reset,
  mcycle_unit_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_e             r_state, w_next;
  mcycle_op_e         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_orig1, r_rem;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_lo, r_neg_hi;
  logic [WIDTH-1:0]   r_res1, r_res2;
  logic               r_done, r_divzero;

  logic               w_accept, w_last, w_busy;
  logic               w_in_div, w_in_signed, w_s1, w_s2, w_is_div;
  logic [WIDTH-1:0]   w_mag1, w_mag2, w_quo, w_rem;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod;

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_accept = 1'b1;
          w_next   = COMPUTE;
        end
      end
      COMPUTE: if (w_last) w_next = FIXUP;
      FIXUP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_busy = (r_state != IDLE) | (w_accept & ~Reset);
  end

  always_comb begin
    w_in_div    = (bus.MCycleOp == OP_DIVU) || (bus.MCycleOp == OP_DIVS);
    w_in_signed = (bus.MCycleOp == OP_MULS) || (bus.MCycleOp == OP_DIVS);
    w_s1        = w_in_signed & bus.Operand1[WIDTH-1];
    w_s2        = w_in_signed & bus.Operand2[WIDTH-1];
    // MIN keeps its bit pattern here, read back as unsigned 2^(WIDTH-1).
    w_mag1      = w_s1 ? (~bus.Operand1 + WIDTH'(1)) : bus.Operand1;
    w_mag2      = w_s2 ? (~bus.Operand2 + WIDTH'(1)) : bus.Operand2;
    w_is_div    = (r_op == OP_DIVU) || (r_op == OP_DIVS);

    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_shift = {r_rem, r_acc[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};

    w_prod = r_neg_lo ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    w_quo  = r_neg_lo ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    w_rem  = r_neg_hi ? (~r_rem + WIDTH'(1)) : r_rem;
  end

  // The low half of r_acc holds the multiplier (MUL) or the dividend that is
  // shifted out while quotient bits shift in (DIV).
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_op      <= OP_MULU;
      r_a       <= '0;
      r_b       <= '0;
      r_orig1   <= '0;
      r_rem     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_res1    <= '0;
      r_res2    <= '0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= bus.MCycleOp;
            r_a       <= w_mag1;
            r_b       <= w_mag2;
            r_orig1   <= bus.Operand1;
            r_rem     <= '0;
            r_acc     <= w_in_div ? {{WIDTH{1'b0}}, w_mag1} : {{WIDTH{1'b0}}, w_mag2};
            r_cnt     <= '0;
            r_neg_lo  <= w_s1 ^ w_s2;
            r_neg_hi  <= w_s1;
            r_divzero <= 1'b0;
          end
        end
        COMPUTE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_is_div) begin
            r_rem              <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
        end
        FIXUP: begin
          r_done <= 1'b1;
          if (w_is_div) begin
            if (r_b == '0) begin
              r_res1    <= '1;
              r_res2    <= r_orig1;
              r_divzero <= 1'b1;
            end else begin
              r_res1 <= w_quo;
              r_res2 <= w_rem;
            end
          end else begin
            r_res1 <= w_prod[WIDTH-1:0];
            r_res2 <= w_prod[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = w_busy;
  assign bus.Done    = r_done;
  assign bus.DivZero = r_divzero;
  assign bus.Result1 = r_res1;
  assign bus.Result2 = r_res2;

endmodule
